// File: rtl/knn_pkg.sv
// Shared definitions for the KNN datapath: FSM state encoding and the
// distance "infinity" value used before any classification has completed.
package knn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VOTE    = 2'd2,
        ST_DONE    = 2'd3
    } knn_state_e;

    // Largest positive value of a W-bit word with the MSB clear.
    function automatic logic [31:0] dist_max(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/knn_sorted_list.sv
// K-slot list kept in ascending distance order; a new entry lands behind all
// entries with an equal or smaller distance, and the last slot falls off.
module knn_sorted_list #(
    parameter int W = 8,
    parameter int K = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           ins_i,
    input  logic [W-1:0]   dist_i,
    input  logic [W-1:0]   type_i,
    output logic [K-1:0]   slot_vld_o,
    output logic [K*W-1:0] slot_type_o,
    output logic [W-1:0]   head_dist_o
);

    logic [K-1:0] vld_q;
    logic [W-1:0] dist_q [K];
    logic [W-1:0] type_q [K];
    logic [K-1:0] le;

    // Valid slots form a sorted prefix, so le is a run of ones followed by zeros.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            le[j] = vld_q[j] && (dist_q[j] <= dist_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int j = 0; j < K; j++) begin
                dist_q[j] <= '0;
                type_q[j] <= '0;
            end
        end else if (clr_i) begin
            vld_q <= '0;
        end else if (ins_i) begin
            if (!le[0]) begin
                vld_q[0]  <= 1'b1;
                dist_q[0] <= dist_i;
                type_q[0] <= type_i;
            end
            for (int j = 1; j < K; j++) begin
                if (!le[j]) begin
                    if (le[j-1]) begin
                        vld_q[j]  <= 1'b1;
                        dist_q[j] <= dist_i;
                        type_q[j] <= type_i;
                    end else begin
                        vld_q[j]  <= vld_q[j-1];
                        dist_q[j] <= dist_q[j-1];
                        type_q[j] <= type_q[j-1];
                    end
                end
            end
        end
    end

    always_comb begin
        slot_type_o = '0;
        for (int j = 0; j < K; j++) begin
            slot_type_o[j*W +: W] = type_q[j];
        end
    end

    assign slot_vld_o  = vld_q;
    assign head_dist_o = dist_q[0];

endmodule

// File: rtl/knn_vote_unit.sv
// Collects L distance results into a K-nearest list, then majority-votes the
// neighbour types one slot per cycle and pulses the winning type.
module knn_vote_unit
    import knn_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 3,
    parameter int L = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_distance,
    input  logic [W-1:0] in_type,
    output logic         busy,
    output logic         class_valid,
    output logic [W-1:0] class_out,
    output logic [W-1:0] nearest_distance
);

    localparam int CNTW = $clog2(L + 1);
    localparam int IW   = (K > 1) ? $clog2(K) : 1;
    localparam int CW   = $clog2(K + 1);

    knn_state_e      state_q;
    logic [CNTW-1:0] cnt_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   best_cnt_q;
    logic [W-1:0]    best_q;
    logic            busy_q;
    logic            class_valid_q;
    logic [W-1:0]    class_out_q;
    logic [W-1:0]    nearest_q;

    logic [K-1:0]    slot_vld;
    logic [K*W-1:0]  slot_type;
    logic [W-1:0]    head_dist;
    logic [W-1:0]    types [K];
    logic [W-1:0]    sel_type;
    logic            sel_vld;
    logic [CW-1:0]   vote_cnt;
    logic            list_ins;

    // start outranks a coincident sample, so the list never inserts on a start cycle.
    assign list_ins = (state_q == ST_COLLECT) && in_valid && !start;

    knn_sorted_list #(.W(W), .K(K)) u_list (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start),
        .ins_i       (list_ins),
        .dist_i      (in_distance),
        .type_i      (in_type),
        .slot_vld_o  (slot_vld),
        .slot_type_o (slot_type),
        .head_dist_o (head_dist)
    );

    always_comb begin
        for (int j = 0; j < K; j++) begin
            types[j] = slot_type[j*W +: W];
        end
        sel_vld  = slot_vld[idx_q];
        sel_type = types[idx_q];
        vote_cnt = '0;
        for (int j = 0; j < K; j++) begin
            if (slot_vld[j] && (types[j] == sel_type)) vote_cnt = vote_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            best_cnt_q    <= '0;
            best_q        <= '0;
            busy_q        <= 1'b0;
            class_valid_q <= 1'b0;
            class_out_q   <= '0;
            nearest_q     <= W'(dist_max(W));
        end else begin
            class_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (start) begin
                        cnt_q <= '0;
                    end else if (in_valid) begin
                        if (cnt_q == CNTW'(L - 1)) begin
                            state_q    <= ST_VOTE;
                            cnt_q      <= '0;
                            idx_q      <= '0;
                            best_cnt_q <= '0;
                            best_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNTW'(1);
                        end
                    end
                end
                ST_VOTE: begin
                    if (start) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= '0;
                    end else begin
                        // Strict compare: on equal counts the earlier (nearer) slot keeps the win.
                        if (sel_vld && (vote_cnt > best_cnt_q)) begin
                            best_cnt_q <= vote_cnt;
                            best_q     <= sel_type;
                        end
                        if (idx_q == IW'(K - 1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    class_valid_q <= 1'b1;
                    class_out_q   <= best_q;
                    nearest_q     <= head_dist;
                    if (start) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign class_valid      = class_valid_q;
    assign class_out        = class_out_q;
    assign nearest_distance = nearest_q;

endmodule

// File: tb/tb_knn_vote_unit.sv
// Directed bench for knn_vote_unit: one instance with K=3/L=4 and one with
// K=2/L=2 share the input stream; each scenario task checks its own results.
module tb_knn_vote_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_distance = '0;
    logic [W-1:0] in_type = '0;

    logic         busy_a, cv_a, busy_b, cv_b;
    logic [W-1:0] co_a, nd_a, co_b, nd_b;

    int checks = 0;
    int errors = 0;
    int cv_cnt_a = 0;

    knn_vote_unit #(.W(W), .K(3), .L(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_distance(in_distance), .in_type(in_type),
        .busy(busy_a), .class_valid(cv_a), .class_out(co_a), .nearest_distance(nd_a)
    );

    knn_vote_unit #(.W(W), .K(2), .L(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_distance(in_distance), .in_type(in_type),
        .busy(busy_b), .class_valid(cv_b), .class_out(co_b), .nearest_distance(nd_b)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cv_a === 1'b1) cv_cnt_a++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] t);
        in_valid    = 1'b1;
        in_distance = d;
        in_type     = t;
        step();
        in_valid    = 1'b0;
    endtask

    task automatic wait_cv_a(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            step();
            if (cv_a === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_cv_b(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            step();
            if (cv_b === 1'b1) got = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit got;
        rst = 1'b0;
        step();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
        checks++; if (cv_a !== 1'b0) begin errors++; $display("FAIL reset_cv: got %0b expected 0", cv_a); end
        checks++; if (co_a !== 8'h00) begin errors++; $display("FAIL reset_class: got %0h expected 00", co_a); end
        checks++; if (nd_a !== 8'h7F) begin errors++; $display("FAIL reset_nearest: got %0h expected 7f", nd_a); end
        rst = 1'b1;
        step();
        pulse_start();
        send(8'd1, 8'd9);
        send(8'd2, 8'd9);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL collect_busy: got %0b expected 1", busy_a); end
        rst = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %0b expected 0", busy_a); end
        checks++; if (cv_a !== 1'b0) begin errors++; $display("FAIL async_reset_cv: got %0b expected 0", cv_a); end
        checks++; if (nd_a !== 8'h7F) begin errors++; $display("FAIL async_reset_nearest: got %0h expected 7f", nd_a); end
        step();
        rst = 1'b1;
        step();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %0b expected 0", busy_a); end
        pulse_start();
        send(8'd50, 8'd5);
        send(8'd60, 8'd6);
        send(8'd70, 8'd6);
        send(8'd80, 8'd7);
        wait_cv_a(10, got);
        checks++; if (!got) begin errors++; $display("FAIL post_reset_timeout: got no class_valid expected pulse"); end
        checks++; if (co_a !== 8'd6) begin errors++; $display("FAIL post_reset_class: got %0d expected 6", co_a); end
        checks++; if (nd_a !== 8'd50) begin errors++; $display("FAIL post_reset_nearest: got %0d expected 50", nd_a); end
    endtask

    task automatic test_basic();
        do_reset();
        pulse_start();
        send(8'd40, 8'd1);
        send(8'd10, 8'd2);
        send(8'd30, 8'd2);
        send(8'd20, 8'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (cv_a !== (k == 4)) begin
                errors++; $display("FAIL latency_k%0d: got %0b expected %0b", k, cv_a, (k == 4));
            end
            if (k == 1) begin
                checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL vote_busy: got %0b expected 1", busy_a); end
            end
        end
        checks++; if (co_a !== 8'd2) begin errors++; $display("FAIL basic_class: got %0d expected 2", co_a); end
        checks++; if (nd_a !== 8'd10) begin errors++; $display("FAIL basic_nearest: got %0d expected 10", nd_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %0b expected 0", busy_a); end
        step();
        checks++; if (cv_a !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %0b expected 0", cv_a); end
        checks++; if (co_a !== 8'd2) begin errors++; $display("FAIL basic_class_hold: got %0d expected 2", co_a); end
    endtask

    task automatic test_tie();
        bit got;
        do_reset();
        pulse_start();
        send(8'd5, 8'd3);
        send(8'd9, 8'd7);
        wait_cv_b(8, got);
        checks++; if (!got) begin errors++; $display("FAIL tie_timeout: got no class_valid expected pulse"); end
        checks++; if (co_b !== 8'd3) begin errors++; $display("FAIL tie_class: got %0d expected 3", co_b); end
        checks++; if (nd_b !== 8'd5) begin errors++; $display("FAIL tie_nearest: got %0d expected 5", nd_b); end
        pulse_start();
        send(8'd9, 8'd7);
        send(8'd5, 8'd3);
        wait_cv_b(8, got);
        checks++; if (!got) begin errors++; $display("FAIL tie_rev_timeout: got no class_valid expected pulse"); end
        checks++; if (co_b !== 8'd3) begin errors++; $display("FAIL tie_rev_class: got %0d expected 3", co_b); end
        checks++; if (nd_b !== 8'd5) begin errors++; $display("FAIL tie_rev_nearest: got %0d expected 5", nd_b); end
    endtask

    task automatic test_equal_dist();
        bit got;
        do_reset();
        pulse_start();
        send(8'd10, 8'd1);
        send(8'd10, 8'd2);
        send(8'd10, 8'd3);
        send(8'd10, 8'd4);
        wait_cv_a(10, got);
        checks++; if (!got) begin errors++; $display("FAIL equal_timeout: got no class_valid expected pulse"); end
        checks++; if (co_a !== 8'd1) begin errors++; $display("FAIL equal_class: got %0d expected 1", co_a); end
        checks++; if (nd_a !== 8'd10) begin errors++; $display("FAIL equal_nearest: got %0d expected 10", nd_a); end
        pulse_start();
        send(8'd10, 8'd4);
        send(8'd10, 8'd5);
        send(8'd10, 8'd6);
        send(8'd10, 8'd6);
        wait_cv_a(10, got);
        checks++; if (!got) begin errors++; $display("FAIL equal2_timeout: got no class_valid expected pulse"); end
        checks++; if (co_a !== 8'd4) begin errors++; $display("FAIL equal2_class: got %0d expected 4", co_a); end
    endtask

    task automatic test_abort();
        bit got;
        int base;
        do_reset();
        base = cv_cnt_a;
        pulse_start();
        send(8'd0, 8'd9);
        send(8'd0, 8'd9);
        pulse_start();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL abort_busy: got %0b expected 1", busy_a); end
        send(8'd3, 8'd8);
        send(8'd4, 8'd8);
        send(8'd200, 8'd1);
        send(8'd1, 8'd5);
        in_valid    = 1'b1;
        in_distance = 8'd0;
        in_type     = 8'd9;
        step();
        step();
        in_valid = 1'b0;
        wait_cv_a(6, got);
        checks++; if (!got) begin errors++; $display("FAIL abort_timeout: got no class_valid expected pulse"); end
        checks++; if (co_a !== 8'd8) begin errors++; $display("FAIL abort_class: got %0d expected 8", co_a); end
        checks++; if (nd_a !== 8'd1) begin errors++; $display("FAIL abort_nearest: got %0d expected 1", nd_a); end
        step();
        checks++; if (cv_cnt_a - base !== 1) begin errors++; $display("FAIL abort_pulse_count: got %0d expected 1", cv_cnt_a - base); end
    endtask

    task automatic test_start_collide();
        bit got;
        int base;
        do_reset();
        base = cv_cnt_a;
        pulse_start();
        send(8'd50, 8'd1);
        start       = 1'b1;
        in_valid    = 1'b1;
        in_distance = 8'd0;
        in_type     = 8'd9;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        send(8'd20, 8'd2);
        send(8'd30, 8'd3);
        send(8'd40, 8'd3);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL collide_still_collect: got %0b expected 1", busy_a); end
        send(8'd60, 8'd4);
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (cv_a !== 1'b0) begin errors++; $display("FAIL collide_early_k%0d: got %0b expected 0", k, cv_a); end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (cv_a !== 1'b1) begin errors++; $display("FAIL done_start_cv: got %0b expected 1", cv_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL done_start_busy: got %0b expected 1", busy_a); end
        checks++; if (co_a !== 8'd3) begin errors++; $display("FAIL collide_class: got %0d expected 3", co_a); end
        checks++; if (nd_a !== 8'd20) begin errors++; $display("FAIL collide_nearest: got %0d expected 20", nd_a); end
        step();
        checks++; if (cv_a !== 1'b0) begin errors++; $display("FAIL done_start_pulse_width: got %0b expected 0", cv_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL done_start_collect: got %0b expected 1", busy_a); end
        checks++; if (cv_cnt_a - base !== 1) begin errors++; $display("FAIL collide_pulse_count: got %0d expected 1", cv_cnt_a - base); end
        send(8'd7, 8'd2);
        send(8'd8, 8'd2);
        send(8'd9, 8'd4);
        send(8'd6, 8'd4);
        wait_cv_a(10, got);
        checks++; if (!got) begin errors++; $display("FAIL restart_timeout: got no class_valid expected pulse"); end
        checks++; if (co_a !== 8'd2) begin errors++; $display("FAIL restart_class: got %0d expected 2", co_a); end
        checks++; if (nd_a !== 8'd6) begin errors++; $display("FAIL restart_nearest: got %0d expected 6", nd_a); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_equal_dist();
        test_abort();
        test_start_collide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
